// File: rtl/debounce_multi_pkg.sv
// Shared constants for the multi-channel debouncer.
// BOARD_STABLE_CYCLES : board default qualification time (30e6 cycles, ~0.6 s at 50 MHz).
// DEFAULT_SYNC_STAGES : default synchroniser depth per channel.
package debounce_multi_pkg;

  localparam int unsigned BOARD_STABLE_CYCLES = 30000000;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_multi_channel.sv
// One debouncer channel: input synchroniser, restart-on-glitch stability
// counter, debounced level and registered one-cycle edge pulses.
// Ports:
//   clock   in  system clock
//   reset   in  synchronous active-high reset
//   raw_i   in  asynchronous raw input
//   level_o out debounced level
//   rise_o  out one-cycle pulse coincident with level_o going 0->1
//   fall_o  out one-cycle pulse coincident with level_o going 1->0
//   busy_o  out a candidate change is being qualified (counter nonzero)
module debounce_multi_channel #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      // Any return to the current level restarts qualification.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = |cnt_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button/switch debouncer. Each channel is filtered
// independently; busy reports that any channel has a pending change.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous active-high reset
//   raw_in     in  [CHANNELS] asynchronous raw inputs, bit i = channel i
//   level_out  out [CHANNELS] debounced levels
//   rise_pulse out [CHANNELS] one-cycle pulse on level 0->1
//   fall_pulse out [CHANNELS] one-cycle pulse on level 1->0
//   busy       out OR of all channels with a nonzero stability counter
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = BOARD_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                busy
);

  logic [CHANNELS-1:0] busy_ch;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_multi_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_in[i]),
      .level_o (level_out[i]),
      .rise_o  (rise_pulse[i]),
      .fall_o  (fall_pulse[i]),
      .busy_o  (busy_ch[i])
    );
  end

  assign busy = |busy_ch;

endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SYNC = 2;

  logic           clock;
  logic           reset;
  logic [NCH-1:0] raw_in;

  // Instance 0: STABLE_CYCLES=8, instance 1: STABLE_CYCLES=1 (same stimulus).
  logic [NCH-1:0] lvl0, rise0, fall0;
  logic           busy0;
  logic [NCH-1:0] lvl1, rise1, fall1;
  logic           busy1;

  debounce_multi #(
    .CHANNELS      (NCH),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (SYNC),
    .RESET_LEVEL   (1'b0)
  ) dut0 (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .level_out  (lvl0),
    .rise_pulse (rise0),
    .fall_pulse (fall0),
    .busy       (busy0)
  );

  debounce_multi #(
    .CHANNELS      (NCH),
    .STABLE_CYCLES (1),
    .SYNC_STAGES   (SYNC),
    .RESET_LEVEL   (1'b0)
  ) dut1 (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (raw_in),
    .level_out  (lvl1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .busy       (busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: histories of raw samples and synchronised values.
  // A channel flips when its last S synchronised values (since reset) all
  // oppose the current level; it is pending while the newest one opposes it.
  int unsigned    SC [2] = '{8, 1};
  logic [63:0]    rawh [NCH];
  int unsigned    rawn;
  logic [63:0]    svh [2][NCH];
  int unsigned    svn [2];
  logic [NCH-1:0] mlvl [2];
  logic [NCH-1:0] mrise [2];
  logic [NCH-1:0] mfall [2];
  logic           mbusy [2];
  int unsigned    rc2;

  task automatic model_edge();
    logic        s;
    logic [63:0] mask;
    if (reset) begin
      rawn = 0;
      for (int m = 0; m < 2; m++) begin
        svn[m] = 0; mlvl[m] = '0; mrise[m] = '0; mfall[m] = '0; mbusy[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        mrise[m] = '0; mfall[m] = '0; mbusy[m] = 1'b0;
        if (svn[m] < 64) svn[m]++;
        mask = (64'd1 << SC[m]) - 64'd1;
        for (int ch = 0; ch < NCH; ch++) begin
          s = (rawn >= SYNC) ? rawh[ch][SYNC-1] : 1'b0;
          svh[m][ch] = {svh[m][ch][62:0], s};
          if (svn[m] >= SC[m] && ((svh[m][ch] & mask) == (mlvl[m][ch] ? 64'd0 : mask))) begin
            mlvl[m][ch]  = s;
            mrise[m][ch] = s;
            mfall[m][ch] = ~s;
          end
          if (s != mlvl[m][ch]) mbusy[m] = 1'b1;
        end
      end
      for (int ch = 0; ch < NCH; ch++) rawh[ch] = {rawh[ch][62:0], raw_in[ch]};
      if (rawn < 64) rawn++;
    end
  endtask

  task automatic check(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("lvl_s8",  lvl0,  mlvl[0]);
    check("rise_s8", rise0, mrise[0]);
    check("fall_s8", fall0, mfall[0]);
    check("busy_s8", {3'b000, busy0}, {3'b000, mbusy[0]});
    check("lvl_s1",  lvl1,  mlvl[1]);
    check("rise_s1", rise1, mrise[1]);
    check("fall_s1", fall1, mfall[1]);
    check("busy_s1", {3'b000, busy1}, {3'b000, mbusy[1]});
    if (rise0[2]) rc2++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rc2 = 0;
    rawn = 0;
    for (int ch = 0; ch < NCH; ch++) rawh[ch] = '0;
    for (int m = 0; m < 2; m++) begin
      svn[m] = 0; mlvl[m] = '0; mrise[m] = '0; mfall[m] = '0; mbusy[m] = 1'b0;
      for (int ch = 0; ch < NCH; ch++) svh[m][ch] = '0;
    end
    reset  = 1'b1;
    raw_in = 4'b1111;

    // Reset held 3 cycles with all raw inputs high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_lvl", lvl0, 4'b0000);
      check("rst_pulse", rise0 | fall0, 4'b0000);
      check("rst_busy", {3'b000, busy0}, 4'b0000);
    end
    reset  = 1'b0;
    raw_in = 4'b0000;
    ticks(12);

    // Clean step on channel 0: edge 1 is the first to sample it.
    raw_in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 2)  check("s1_step_before", {3'b000, lvl1[0]}, 4'b0000);
      if (e == 3)  check("s1_step_at", {3'b000, lvl1[0] & rise1[0]}, 4'b0001);
      if (e == 9)  check("step_before", {3'b000, lvl0[0]}, 4'b0000);
      if (e == 10) check("step_at", {3'b000, lvl0[0] & rise0[0]}, 4'b0001);
      if (e == 11) check("step_pulse_end", {3'b000, rise0[0]}, 4'b0000);
    end

    // Glitches of 5 and 7 cycles rejected; 8 cycles accepted.
    raw_in[1] = 1'b1; ticks(5); raw_in[1] = 1'b0; ticks(15);
    check("glitch5", {3'b000, lvl0[1]}, 4'b0000);
    check("glitch5_busy", {3'b000, busy0}, 4'b0000);
    raw_in[1] = 1'b1; ticks(7); raw_in[1] = 1'b0; ticks(15);
    check("glitch7", {3'b000, lvl0[1]}, 4'b0000);
    raw_in[1] = 1'b1; ticks(8); raw_in[1] = 1'b0; ticks(2);
    check("high8", {3'b000, lvl0[1]}, 4'b0010 >> 1);
    ticks(15);

    // Bounce train on channel 2, then settle high.
    rc2 = 0;
    for (int t = 0; t < 10; t++) begin
      raw_in[2] = ~raw_in[2];
      ticks(3);
    end
    raw_in[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 10) check("bounce_rise", {3'b000, rise0[2]}, 4'b0001);
    end
    check("bounce_count", 4'(rc2), 4'd1);

    // Simultaneous fall on channels 0 and 3.
    raw_in[3] = 1'b1; ticks(12);
    raw_in[0] = 1'b0; raw_in[3] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 10) begin
        check("simul_fall", fall0, 4'b1001);
        check("simul_lvl", lvl0 & 4'b1001, 4'b0000);
      end
    end

    // Reset with channel 1 at count 5.
    raw_in[1] = 1'b1; ticks(7);
    check("mid_busy", {3'b000, busy0}, 4'b0001);
    reset = 1'b1; tick();
    check("mid_rst", {lvl0[1], rise0[1], fall0[1], busy0}, 4'b0000);
    reset = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 9)  check("requal_before", {3'b000, lvl0[1]}, 4'b0000);
      if (e == 10) check("requal_at", {3'b000, lvl0[1] & rise0[1]}, 4'b0001);
    end

    // Single-cycle raw pulse on channel 3 through the STABLE_CYCLES=1 copy.
    raw_in[3] = 1'b1; tick(); raw_in[3] = 1'b0;
    for (int e = 2; e <= 6; e++) begin
      tick();
      if (e == 3) check("s1_pulse_rise", {3'b000, rise1[3]}, 4'b0001);
      if (e == 4) check("s1_pulse_fall", {3'b000, fall1[3]}, 4'b0001);
    end

    // Random holds with occasional reset.
    for (int k = 0; k < 60; k++) begin
      raw_in = 4'($urandom);
      reset  = ($urandom_range(0, 24) == 0);
      ticks(int'($urandom_range(1, 12)));
    end
    reset = 1'b0;
    ticks(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
